// File: rtl/smg_scan_mux_pkg.sv
// Shared constants and helpers for the 7-segment scan multiplexer.
package smg_scan_mux_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int DIGITS_MAX = 8;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2Min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/smg_scan_mux_if.sv
// Display bus between a number source (master) and the scan multiplexer (slave).
interface smg_scan_mux_if
#(
    parameter int DIGITS = 4
);
    import smg_scan_mux_pkg::*;

    logic                         En;
    logic [NIBBLE_W*DIGITS-1:0]   NumberSig;
    logic [DIGITS-1:0]            DpSig;
    logic                         BlankLZ;
    logic [NIBBLE_W-1:0]          NumberData;
    logic [DIGITS-1:0]            DigitSel;
    logic                         Dp;
    logic                         FrameStart;

    modport master (
        output En, NumberSig, DpSig, BlankLZ,
        input  NumberData, DigitSel, Dp, FrameStart
    );

    modport slave (
        input  En, NumberSig, DpSig, BlankLZ,
        output NumberData, DigitSel, Dp, FrameStart
    );

endinterface

// File: rtl/smg_scan_mux_tick_gen.sv
// Slot prescaler: counts CLK cycles within one digit slot and flags the last one.
module smg_scan_mux_tick_gen
#(
    parameter int SCAN_TICKS = 500000,
    parameter int CNT_W      = smg_scan_mux_pkg::clog2Min1(SCAN_TICKS)
)(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    output logic             Tick,
    output logic [CNT_W-1:0] Cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_TICKS - 1);

    // Slot end is the final count of the slot, only while scanning.
    assign Tick = En && (Cnt == LAST);

    // Count 0..SCAN_TICKS-1, parked at zero while scanning is disabled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Cnt <= '0;
        end else if (!En || Tick) begin
            Cnt <= '0;
        end else begin
            Cnt <= Cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smg_scan_mux.sv
// Time-multiplexed N-digit 7-segment scan controller with frame-coherent
// snapshot, leading-zero blanking and anti-ghost dead time.
module smg_scan_mux
    import smg_scan_mux_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_TICKS     = 500000,
    parameter int DEAD_TICKS     = 0,
    parameter bit SEL_ACTIVE_LOW = 1'b1
)(
    input  logic           CLK,
    input  logic           RSTn,
    smg_scan_mux_if.slave  bus
);

    localparam int CNT_W = clog2Min1(SCAN_TICKS);
    localparam int PTR_W = clog2Min1(DIGITS);
    localparam logic [PTR_W-1:0]  PTR_FIRST = PTR_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF   = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic                        tick;
    logic [CNT_W-1:0]            cnt;
    logic [PTR_W-1:0]            ptr;
    logic [NIBBLE_W*DIGITS-1:0]  shadowNum;
    logic [DIGITS-1:0]           shadowDp;
    logic                        frameWrap;
    logic                        deadNow;
    logic                        zeroRun;
    logic [DIGITS-1:0]           blankMask;
    logic [NIBBLE_W-1:0]         nib [DIGITS];
    logic [DIGITS-1:0]           selOneHot;
    logic                        curBlank;

    logic [NIBBLE_W-1:0]         numberDataQ;
    logic [DIGITS-1:0]           digitSelQ;
    logic                        dpQ;
    logic                        frameStartQ;

    smg_scan_mux_tick_gen #(
        .SCAN_TICKS (SCAN_TICKS),
        .CNT_W      (CNT_W)
    ) u_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .En   (bus.En),
        .Tick (tick),
        .Cnt  (cnt)
    );

    // The last slot of digit 0 closes the frame; that is where new data is taken.
    assign frameWrap = tick && (ptr == '0);
    // Selects stay dark for the first DEAD_TICKS cycles of every slot.
    assign deadNow   = int'(cnt) < DEAD_TICKS;

    // Digit pointer walks leftmost to rightmost, restarting at the leftmost digit.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr <= PTR_FIRST;
        end else if (!bus.En) begin
            ptr <= PTR_FIRST;
        end else if (tick) begin
            ptr <= (ptr == '0) ? PTR_FIRST : ptr - PTR_W'(1);
        end
    end

    // Shadow copy of the display data; follows the inputs while disabled,
    // otherwise only refreshed at frame wrap so a frame never tears.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shadowNum <= '0;
            shadowDp  <= '0;
        end else if (!bus.En || frameWrap) begin
            shadowNum <= bus.NumberSig;
            shadowDp  <= bus.DpSig;
        end
    end

    // Split shadow into nibbles and mark leading-zero digits (digit 0 never blanks).
    always_comb begin
        zeroRun   = 1'b1;
        blankMask = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib[k] = shadowNum[k*NIBBLE_W +: NIBBLE_W];
        end
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zeroRun      = zeroRun && (nib[k] == '0);
            blankMask[k] = bus.BlankLZ && zeroRun;
        end
    end

    // Active-high one-hot select for the current digit.
    always_comb begin
        selOneHot      = '0;
        selOneHot[ptr] = 1'b1;
        curBlank       = blankMask[ptr];
    end

    // Registered outputs from this cycle's counter, pointer and shadow.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            numberDataQ <= '0;
            digitSelQ   <= SEL_OFF;
            dpQ         <= 1'b0;
            frameStartQ <= 1'b0;
        end else if (!bus.En) begin
            numberDataQ <= '0;
            digitSelQ   <= SEL_OFF;
            dpQ         <= 1'b0;
            frameStartQ <= 1'b0;
        end else begin
            numberDataQ <= curBlank ? '0 : nib[ptr];
            dpQ         <= !curBlank && shadowDp[ptr];
            frameStartQ <= frameWrap;
            if (curBlank || deadNow) begin
                digitSelQ <= SEL_OFF;
            end else begin
                digitSelQ <= SEL_ACTIVE_LOW ? ~selOneHot : selOneHot;
            end
        end
    end

    assign bus.NumberData = numberDataQ;
    assign bus.DigitSel   = digitSelQ;
    assign bus.Dp         = dpQ;
    assign bus.FrameStart = frameStartQ;

endmodule
